fc_cim_ctrl: RTL
================

Name: fc_cim_ctrl

Overview:
- Layer-level sequencer for one fully connected (MLP) layer.
- Accepts a start from the previous layer and loads input vectors into the v_cim_tiles x h_cim_tiles crossbar array.
- Issues one bit-serial compute per input bit-plane, then hands the accumulated results to the layer's func unit with a start/busy handshake.
- Sits between the previous layer's func unit (upstream) and this layer's CIM tiles plus fc_func (downstream).

Parameters:
- input_size, 201, number of input activations of the layer
- xbar_size, 256, crossbar rows/columns per tile
- v_cim_tiles, ceil(input_size/xbar_size), vertically stacked tiles
- datatype_size, 8, input activation width; one compute per bit
- cim_latency, 4, cycles from o_cim_compute pulse to valid tile outputs (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- i_start  in  1  previous layer has a full input vector ready
- o_busy  out  1  this layer cannot accept a new input vector
- o_in_addr  out  $clog2(xbar_size)  row address into the input buffer and crossbar input registers
- o_in_we  out  1  write enable for the crossbar input registers (all v tiles in parallel)
- o_cim_compute  out  1  one-cycle pulse, start analog MVM on all tiles
- o_cim_bit  out  $clog2(datatype_size)  bit-plane index for the current compute; tiles shift-accumulate
- o_cim_busy  out  1  to fc_func i_cim_busy; tiles are loading or computing
- i_func_busy  in  1  fc_func o_busy
- o_func_start  out  1  to fc_func i_start

Behaviour:
- Reset (rst=0, async): state S_IDLE, all counters 0, every output 0.
- States and transitions:
  - S_IDLE: o_busy=0. If i_start=1 → S_LOAD (o_busy=1 from the next cycle).
  - S_LOAD: o_in_we=1, o_in_addr=load_cnt, o_cim_busy=1. load_cnt increments each cycle. When load_cnt = min(input_size, xbar_size)-1 → S_COMPUTE with bit_cnt=0 and load_cnt cleared. Rows at or above input_size within a tile are written by the buffer as zeros; the controller always sweeps to min(input_size, xbar_size)-1.
  - S_COMPUTE: o_cim_busy=1. First cycle: o_cim_compute=1, o_cim_bit=bit_cnt, lat_cnt=0. Then wait until lat_cnt = cim_latency-1. At that point, if bit_cnt = datatype_size-1 → S_WAIT_FUNC; else bit_cnt+1 and issue the next compute on the following cycle.
  - S_WAIT_FUNC: o_cim_busy=0. If i_func_busy=0 → S_HANDOFF; else stay (results held in tiles).
  - S_HANDOFF: o_func_start=1, held level. When i_func_busy=1 is sampled → S_IDLE. o_func_start drops in that same transition.
- o_busy=1 in every state except S_IDLE. The upstream unit must not reassert i_start until o_busy falls.
- i_start while not in S_IDLE: ignored, not queued.
- Output timing:
  - o_cim_compute is exactly one cycle wide.
  - Compute pulses for successive bits are spaced cim_latency+1 cycles apart.
  - Total busy cycles (no func stall) = min(input_size, xbar_size) + datatype_size*(cim_latency+1) + 2.
- Counters: load_cnt is $clog2(xbar_size) bits, bit_cnt is $clog2(datatype_size) bits, lat_cnt is $clog2(cim_latency+1) bits. No wrap occurs beyond the terminal values above.
- Reset asserted mid-operation: immediate return to S_IDLE, outputs 0. Partial tile contents are discarded by design.
- Simultaneous events: i_func_busy rising in S_WAIT_FUNC keeps the block waiting. Only a 0 sampled in S_WAIT_FUNC advances it.

Optional Feature:
- Macro: FC_CIM_CTRL_PERF_EN.
- Defined: adds output o_perf_cycles (32 bits) and o_perf_stall (32 bits).
  - o_perf_cycles counts cycles with o_busy=1.
  - o_perf_stall counts cycles spent in S_WAIT_FUNC plus S_HANDOFF.
  - Both counters saturate at all-ones and clear only on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fc_pkg:
  - typedef enum t_ctrl_state {S_IDLE, S_LOAD, S_COMPUTE, S_WAIT_FUNC, S_HANDOFF}
  - ceil-division helper function used for h_cim_tiles/v_cim_tiles
- Sub-module: fc_ctrl_counter, a parameterised terminal-count counter with clear/enable and a done flag. It is instantiated three times (load, bit, latency).

Test Plan:
- Basic run (input_size=201, xbar_size=256, datatype_size=8, cim_latency=4): pulse i_start with i_func_busy=0 → o_in_we high for 201 cycles (addr 0..200); 8 o_cim_compute pulses with o_cim_bit 0..7, each 5 cycles apart; o_func_start asserted; o_busy low 1 cycle after i_func_busy rises.
- Func stall: hold i_func_busy=1 for 50 cycles after compute → o_cim_busy=0, no o_func_start during stall; o_func_start appears the cycle after i_func_busy falls.
- Ignored start: pulse i_start during S_COMPUTE → no change in sequence, exactly 8 computes, single o_func_start.
- Async reset mid-load (rst=0 at load_cnt=100, between clock edges) → all outputs 0 immediately; after release, i_start restarts with o_in_addr=0.
- Boundary sizes: input_size=256, datatype_size=1, cim_latency=1 → 256 load cycles, one compute with o_cim_bit=0, total busy cycles 256+2+2=260.
- PERF_EN build: run the basic scenario with a 10-cycle func stall → o_perf_stall=11 (10 stall cycles in S_WAIT_FUNC + 1 cycle in S_HANDOFF); o_perf_cycles equals the total count of o_busy=1 cycles.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the fully connected layer controller.
package fc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_WAIT_FUNC,
        S_HANDOFF
    } t_ctrl_state;

    // Tile count along one crossbar dimension (h_cim_tiles / v_cim_tiles).
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Counter/port width that never collapses to zero bits for a count of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_ctrl_counter.sv
// Terminal-count counter: wraps to zero when enabled at the terminal value.
module fc_ctrl_counter #(
    parameter int width    = 8,
    parameter int terminal = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [width-1:0] cnt,
    output logic             done
);

    localparam logic [width-1:0] term_v = width'(terminal);

    assign done = (cnt == term_v);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= done ? '0 : cnt + width'(1);
        end
    end

endmodule

// File: rtl/fc_cim_ctrl.sv
// Layer sequencer for one FC layer: load crossbar inputs, bit-serial compute, hand off to fc_func.
// Optional macro FC_CIM_CTRL_PERF_EN adds saturating busy/stall performance counters.
module fc_cim_ctrl
    import fc_pkg::*;
#(
    parameter int input_size    = 201,
    parameter int xbar_size     = 256,
    parameter int datatype_size = 8,
    parameter int cim_latency   = 4,
    parameter int v_cim_tiles   = ceil_div(input_size, xbar_size)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_start,
    output logic                                o_busy,
    output logic [cnt_width(xbar_size)-1:0]     o_in_addr,
    output logic                                o_in_we,
    output logic                                o_cim_compute,
    output logic [cnt_width(datatype_size)-1:0] o_cim_bit,
    output logic                                o_cim_busy,
    input  logic                                i_func_busy,
    output logic                                o_func_start
`ifdef FC_CIM_CTRL_PERF_EN
    ,
    output logic [31:0]                         o_perf_cycles,
    output logic [31:0]                         o_perf_stall
`endif
);

    localparam int aw = cnt_width(xbar_size);
    localparam int bw = cnt_width(datatype_size);
    localparam int lw = cnt_width(cim_latency + 1);
    // Stacked tiles are loaded in parallel, so a multi-tile layer sweeps a full crossbar height.
    localparam int load_rows = (v_cim_tiles > 1) ? xbar_size : input_size;

    t_ctrl_state state, state_nxt;

    logic          cnt_clr, load_en, lat_en, bit_en;
    logic          load_done, lat_done, bit_done;
    logic [aw-1:0] load_cnt;
    logic [bw-1:0] bit_cnt;
    logic [lw-1:0] lat_cnt;

    assign cnt_clr = (state == S_IDLE);

    fc_ctrl_counter #(.width(aw), .terminal(load_rows - 1)) u_load_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(load_en), .cnt(load_cnt), .done(load_done)
    );

    fc_ctrl_counter #(.width(bw), .terminal(datatype_size - 1)) u_bit_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(bit_en), .cnt(bit_cnt), .done(bit_done)
    );

    // Phase 0 issues the compute pulse; phases 1..cim_latency wait for tile outputs.
    fc_ctrl_counter #(.width(lw), .terminal(cim_latency)) u_lat_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(lat_en), .cnt(lat_cnt), .done(lat_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output and enable gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        load_en       = 1'b0;
        lat_en        = 1'b0;
        bit_en        = 1'b0;
        o_busy        = 1'b1;
        o_in_we       = 1'b0;
        o_in_addr     = '0;
        o_cim_compute = 1'b0;
        o_cim_bit     = '0;
        o_cim_busy    = 1'b0;
        o_func_start  = 1'b0;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                o_in_we    = 1'b1;
                o_in_addr  = load_cnt;
                o_cim_busy = 1'b1;
                load_en    = 1'b1;
                if (load_done) state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                o_cim_busy    = 1'b1;
                o_cim_bit     = bit_cnt;
                o_cim_compute = (lat_cnt == '0);
                lat_en        = 1'b1;
                bit_en        = lat_done;
                if (lat_done && bit_done) state_nxt = S_WAIT_FUNC;
            end
            S_WAIT_FUNC: begin
                if (!i_func_busy) state_nxt = S_HANDOFF;
            end
            S_HANDOFF: begin
                o_func_start = 1'b1;
                if (i_func_busy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef FC_CIM_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_perf_cycles <= '0;
            o_perf_stall  <= '0;
        end else begin
            if (o_busy && (o_perf_cycles != '1))
                o_perf_cycles <= o_perf_cycles + 32'd1;
            if (((state == S_WAIT_FUNC) || (state == S_HANDOFF)) && (o_perf_stall != '1))
                o_perf_stall <= o_perf_stall + 32'd1;
        end
    end
`endif

endmodule
